bus_arb2_32: RTL and testbench

BUS_ARB2_32 -- requirements
Module: bus_arb2_32

---
 rtl/bus_arb2_32_pkg.sv | 24 ++
 rtl/bus_arb2_32_if.sv | 33 +++
 rtl/MUX2T1_32.sv | 9 +
 rtl/bus_arb2_32.sv | 106 ++++++++++
 tb/tb_bus_arb2_32.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb2_32_pkg.sv
// Shared definitions for the two-requester 32-bit bus arbiter:
// FSM encoding, grant codes, default timeout and the arbitration decision.
package bus_arb2_32_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  // Returns the winning requester index (0 or 1). On a tie, round-robin picks
  // the requester that was not served last; fixed priority always picks 0.
  function automatic logic arb_pick(input logic r0, input logic r1,
                                    input logic last, input logic rr);
    if (r0 && r1) return rr ? ~last : 1'b0;
    return r1 & ~r0;
  endfunction

endpackage

// File: rtl/bus_arb2_32_if.sv
// Requester and shared-memory signals of the arbiter. The arbiter uses the
// slave modport; the requesters/memory model use the master modport.
interface bus_arb2_32_if;
  import bus_arb2_32_pkg::*;

  logic              req0, req1;
  logic [DATA_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              we0, we1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [1:0]        gnt;
  logic              mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    input  mem_rdata, mem_ack,
    output ack0, ack1, rdata, err, gnt,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    output mem_rdata, mem_ack,
    input  ack0, ack1, rdata, err, gnt,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/MUX2T1_32.sv
// Team 32-bit 2:1 multiplexer: y = d1 when sel is high, else d0.
module MUX2T1_32 (
  input  logic        sel,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [31:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/bus_arb2_32.sv
// Two-requester arbiter onto a single 32-bit memory port with a per-transfer
// ack timeout. Three-state FSM: IDLE (arbitrate), BUSY (memory access), RESP (ack).
module bus_arb2_32
  import bus_arb2_32_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int RR_EN       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arb2_32_if.slave bus
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

  logic [1:0]        state;
  logic              sel;
  logic              last;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [1:0]        gnt_q;

  logic              win;
  logic              busy;
  logic              resp;
  logic              mux_sel;
  logic              timeout;

  assign busy    = (state == BUSY);
  assign resp    = (state == RESP);
  assign win     = arb_pick(bus.req0, bus.req1, last, RR_EN != 0);
  assign timeout = (({1'b0, cnt} + 9'd1) == TO_LIM);

  // Outside BUSY the memory port shows requester 0, so the mux select is gated.
  assign mux_sel = busy & sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gnt_q   <= GNT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel   <= win;
            gnt_q <= win ? GNT_1 : GNT_0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // A same-cycle ack takes precedence over the timeout.
          if (bus.mem_ack) begin
            rdata_q <= bus.mem_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          last  <= sel;
          gnt_q <= GNT_NONE;
          state <= IDLE;
        end
        default: begin
          gnt_q <= GNT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0    = resp & ~sel;
  assign bus.ack1    = resp & sel;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.gnt     = gnt_q;
  assign bus.mem_req = busy;
  assign bus.mem_we  = busy & (sel ? bus.we1 : bus.we0);

  MUX2T1_32 u_mux_addr (
    .sel (mux_sel),
    .d0  (bus.addr0),
    .d1  (bus.addr1),
    .y   (bus.mem_addr)
  );

  MUX2T1_32 u_mux_wdata (
    .sel (mux_sel),
    .d0  (bus.wdata0),
    .d1  (bus.wdata1),
    .y   (bus.mem_wdata)
  );

endmodule

// File: tb/tb_bus_arb2_32.sv
// Self-checking bench for bus_arb2_32: vector table of single transfers plus
// hand-written sequences for arbitration order, idle mem_ack and reset in BUSY.
module tb_bus_arb2_32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arb2_32_if bus ();
  bus_arb2_32_if busb ();

  bus_arb2_32 #(.TIMEOUT_CYC(4), .RR_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bus_arb2_32 #(.TIMEOUT_CYC(255), .RR_EN(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busb)
  );

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          ack_at;   // BUSY cycle carrying mem_ack, 0 = never
    logic [1:0]  gnt;
    int          busy_len;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   checks = 0;
  int   passes = 0;
  logic ack_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard side: every ack pops the oldest expected response.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_who", {30'd0, bus.ack1, bus.ack0}, mon_e.who ? 32'd2 : 32'd1);
        chk("ack_rdata", bus.rdata, mon_e.rdata);
        chk("ack_err", {31'd0, bus.err}, {31'd0, mon_e.err});
      end
      chk("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
    end
    ack_prev <= bus.ack0 | bus.ack1;
  end

  task automatic run_vec(input vec_t v);
    int          n;
    bit          done;
    logic [31:0] a0;
    logic [31:0] d0;
    a0 = v.who ? ~v.addr : v.addr;
    d0 = v.who ? ~v.wdata : v.wdata;
    if (v.who) begin
      bus.addr1 = v.addr;  bus.wdata1 = v.wdata;  bus.we1 = v.we;
      bus.addr0 = ~v.addr; bus.wdata0 = ~v.wdata; bus.we0 = ~v.we;
      bus.req1  = 1'b1;
    end else begin
      bus.addr0 = v.addr;  bus.wdata0 = v.wdata;  bus.we0 = v.we;
      bus.addr1 = ~v.addr; bus.wdata1 = ~v.wdata; bus.we1 = ~v.we;
      bus.req0  = 1'b1;
    end
    bus.mem_rdata = v.mrd;
    sbq.push_back('{v.who, v.rdata, v.err});
    step();
    chk("gnt", {30'd0, bus.gnt}, {30'd0, v.gnt});
    chk("mem_addr", bus.mem_addr, v.addr);
    chk("mem_wdata", bus.mem_wdata, v.wdata);
    chk("mem_we", {31'd0, bus.mem_we}, {31'd0, v.we});
    n = 0;
    done = 0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (bus.mem_req) begin
        n++;
        bus.mem_ack = (n == v.ack_at);
        step();
        bus.mem_ack = 1'b0;
      end else begin
        done = 1;
      end
    end
    chk("busy_len", n, v.busy_len);
    chk("ack_seen", {31'd0, v.who ? bus.ack1 : bus.ack0}, 32'd1);
    chk("resp_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("resp_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("resp_mem_addr", bus.mem_addr, a0);
    chk("resp_mem_wdata", bus.mem_wdata, d0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    chk("idle_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [1:0]  rr_exp[4];

    vecs[0] = '{1'b0, 1'b0, 32'h00000040, 32'h00000000, 32'h1234ABCD, 2, 2'b01, 2, 32'h1234ABCD, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'h55AA55AA, 1, 2'b10, 1, 32'h55AA55AA, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h00000100, 32'h11112222, 32'hFFFFFFFF, 0, 2'b01, 4, 32'h00000000, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h00000104, 32'h33334444, 32'hCAFEF00D, 4, 2'b01, 4, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000000, 32'h0BADC0DE, 3, 2'b10, 3, 32'h0BADC0DE, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h00000020, 32'h5A5A5A5A, 32'h87654321, 0, 2'b10, 4, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    busb.req0 = 0; busb.req1 = 0; busb.we0 = 0; busb.we1 = 0;
    busb.addr0 = 0; busb.addr1 = 0; busb.wdata0 = 0; busb.wdata1 = 0;
    busb.mem_rdata = 0; busb.mem_ack = 0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", {30'd0, bus.gnt}, 32'd0);

    // mem_ack while idle is ignored
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h77777777;
    step();
    step();
    chk("idle_ack_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("idle_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("idle_ack_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("idle_ack_rdata", bus.rdata, 32'd0);
    bus.mem_ack = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Round-robin with both requests held and memory acking every BUSY cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    bus.addr0 = 32'hA0; bus.addr1 = 32'hB0; bus.we0 = 0; bus.we1 = 0;
    bus.mem_rdata = 32'h13579BDF;
    bus.mem_ack = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) sbq.push_back('{rr_exp[i][1], 32'h13579BDF, 1'b0});
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      step();
      if (bus.mem_req) begin
        chk("rr_gnt", {30'd0, bus.gnt}, {30'd0, rr_exp[k]});
        chk("rr_mem_addr", bus.mem_addr, rr_exp[k][1] ? 32'hB0 : 32'hA0);
        k++;
      end
    end
    chk("rr_grants", k, 4);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.mem_ack = 1'b0;
    step();

    // Fixed priority: requester 0 keeps winning
    busb.mem_ack = 1'b1;
    busb.req0 = 1'b1;
    busb.req1 = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      step();
      if (busb.mem_req) begin
        chk("fp_gnt", {30'd0, busb.gnt}, 32'd1);
        k++;
      end
    end
    chk("fp_grants", k, 3);
    step();
    busb.req0 = 1'b0;
    busb.req1 = 1'b0;
    busb.mem_ack = 1'b0;
    step();

    // Reset asserted mid-transfer abandons it without an ack
    bus.addr0 = 32'h200;
    bus.req0 = 1'b1;
    step();
    chk("rb_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rb_gnt", {30'd0, bus.gnt}, 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rb_async_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rb_async_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("rb_async_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    @(negedge clk);
    chk("rb_held_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    bus.addr1 = 32'h300;
    bus.we1 = 1'b0;
    bus.mem_rdata = 32'h00004444;
    bus.req1 = 1'b1;
    sbq.push_back('{1'b1, 32'h00004444, 1'b0});
    step();
    chk("rb_post_gnt", {30'd0, bus.gnt}, 32'd2);
    chk("rb_post_mem_addr", bus.mem_addr, 32'h300);
    bus.mem_ack = 1'b1;
    step();
    chk("rb_post_ack1", {31'd0, bus.ack1}, 32'd1);
    bus.req1 = 1'b0;
    bus.mem_ack = 1'b0;
    step();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
